wb_write_queue: RTL and testbench

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

---
 rtl/wb_write_queue.sv | 120 ++++++++++++
 tb/tb_wb_write_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Register-file writeback arbiter: the main pipeline always wins the single write
// port; multiply/divide results queue in a small FIFO and drain in idle slots.
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_valid,
  input  logic [4:0]               pipe_rd,
  input  logic [31:0]              pipe_data,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_rd,
  input  logic [31:0]              mdu_data,
  output logic                     reg_write,
  output logic [4:0]               rd,
  output logic [31:0]              write_data,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  output logic                     rs_pending,
  output logic                     rt_pending,
  output logic [$clog2(DEPTH):0]   pend_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][4:0]  ent_rd;
  logic [DEPTH-1:0][31:0] ent_data;
  logic [DEPTH-1:0]       ent_vld;
  logic [DEPTH-1:0]       kill;
  logic [DEPTH-1:0]       vld_nxt;
  logic [DEPTH-1:0]       rs_hit, rt_hit;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          occ, occ_nxt;
  logic                   full_q;

  logic pipe_wr, mdu_xfer, fifo_ne, do_pop, do_byp, do_push;

  assign mdu_ready = !full_q;
  assign pipe_wr   = pipe_valid && (pipe_rd != 5'd0);
  assign mdu_xfer  = mdu_valid && !full_q;
  // occ counts occupied slots, including invalidated ones still waiting to drain
  assign fifo_ne   = (occ != '0);
  assign do_pop    = !pipe_wr && fifo_ne;
  assign do_byp    = !pipe_wr && !fifo_ne && mdu_xfer && (mdu_rd != 5'd0);
  assign do_push   = mdu_xfer && (mdu_rd != 5'd0) && !do_byp &&
                     !(pipe_wr && (mdu_rd == pipe_rd));
  assign occ_nxt   = occ + CW'(do_push) - CW'(do_pop);

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      assign kill[g]   = pipe_wr && ent_vld[g] && (ent_rd[g] == pipe_rd);
      assign rs_hit[g] = ent_vld[g] && (ent_rd[g] == rs);
      assign rt_hit[g] = ent_vld[g] && (ent_rd[g] == rt);
    end
  endgenerate

  always_comb begin
    vld_nxt = ent_vld & ~kill;
    if (do_pop)  vld_nxt[rd_ptr] = 1'b0;
    if (do_push) vld_nxt[wr_ptr] = 1'b1;
  end

  always_comb begin
    pend_count = '0;
    for (int i = 0; i < DEPTH; i++)
      pend_count = pend_count + CW'(ent_vld[i]);
  end

  // Hazard view covers only registered state: queued entries and the write in flight.
  assign rs_pending = (rs != 5'd0) && ((|rs_hit) || (reg_write && (rd == rs)));
  assign rt_pending = (rt != 5'd0) && ((|rt_hit) || (reg_write && (rd == rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write  <= 1'b0;
      rd         <= 5'd0;
      write_data <= 32'd0;
      ent_vld    <= '0;
      ent_rd     <= '0;
      ent_data   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      full_q     <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      if (pipe_wr) begin
        reg_write  <= 1'b1;
        rd         <= pipe_rd;
        write_data <= pipe_data;
      end else if (do_pop) begin
        // an invalidated head still burns this slot, but issues no write
        if (ent_vld[rd_ptr]) begin
          reg_write  <= 1'b1;
          rd         <= ent_rd[rd_ptr];
          write_data <= ent_data[rd_ptr];
        end
      end else if (do_byp) begin
        reg_write  <= 1'b1;
        rd         <= mdu_rd;
        write_data <= mdu_data;
      end

      if (do_push) begin
        ent_rd[wr_ptr]   <= mdu_rd;
        ent_data[wr_ptr] <= mdu_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;

      ent_vld <= vld_nxt;
      occ     <= occ_nxt;
      full_q  <= (occ_nxt == CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed vector bench for wb_write_queue (DEPTH=4): inputs driven on the falling
// edge, outputs checked on the following falling edge.
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic [4:0]  rs, rt;
  logic        rs_pending, rt_pending;
  logic [2:0]  pend_count;

  int errors = 0;
  int checks = 0;

  wb_write_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .reg_write(reg_write), .rd(rd), .write_data(write_data),
    .rs(rs), .rt(rt), .rs_pending(rs_pending), .rt_pending(rt_pending),
    .pend_count(pend_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic [4:0]  qs, qt;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_rdy;
    int          e_pc;
    logic        e_rsp, e_rtp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pv, logic [4:0] prd, logic [31:0] pd,
                              logic mv, logic [4:0] mrd, logic [31:0] md,
                              logic [4:0] qs, logic [4:0] qt,
                              logic e_rw, logic [4:0] e_rd, logic [31:0] e_wd,
                              logic e_rdy, int e_pc, logic e_rsp, logic e_rtp);
    vec_t v;
    v.pv = pv; v.prd = prd; v.pd = pd; v.mv = mv; v.mrd = mrd; v.md = md;
    v.qs = qs; v.qt = qt; v.e_rw = e_rw; v.e_rd = e_rd; v.e_wd = e_wd;
    v.e_rdy = e_rdy; v.e_pc = e_pc; v.e_rsp = e_rsp; v.e_rtp = e_rtp;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pipe_valid = v.pv; pipe_rd = v.prd; pipe_data = v.pd;
    mdu_valid = v.mv; mdu_rd = v.mrd; mdu_data = v.md;
    rs = v.qs; rt = v.qt;
  endtask

  task automatic idle();
    pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
    mdu_valid = 1'b0; mdu_rd = '0; mdu_data = '0;
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    chk("reg_write",  idx, 32'(reg_write),  32'(v.e_rw));
    chk("rd",         idx, 32'(rd),         32'(v.e_rd));
    chk("write_data", idx, write_data,      v.e_wd);
    chk("mdu_ready",  idx, 32'(mdu_ready),  32'(v.e_rdy));
    chk("pend_count", idx, 32'(pend_count), 32'(v.e_pc));
    chk("rs_pending", idx, 32'(rs_pending), 32'(v.e_rsp));
    chk("rt_pending", idx, 32'(rt_pending), 32'(v.e_rtp));
  endtask

  initial begin
    // pipe-only write, then hold with no strobe
    vecs.push_back(mk(1,5,'h1234, 0,0,0,    5,0, 1,5,'h1234,1,0,1,0));
    vecs.push_back(mk(0,0,0,      0,0,0,    5,0, 0,5,'h1234,1,0,0,0));
    // pipe/MDU collision
    vecs.push_back(mk(1,3,'hA,    1,7,'hB,  7,3, 1,3,'hA,   1,1,1,1));
    vecs.push_back(mk(0,0,0,      0,0,0,    7,3, 1,7,'hB,   1,0,1,0));
    vecs.push_back(mk(0,0,0,      0,0,0,    7,0, 0,7,'hB,   1,0,0,0));
    // MDU bypass into an idle slot
    vecs.push_back(mk(0,0,0,      1,10,'h55,10,0,1,10,'h55, 1,0,1,0));
    // zero register on both paths
    vecs.push_back(mk(1,0,'h99,   1,0,'h77, 0,0, 0,10,'h55, 1,0,0,0));
    // youngest-wins against a queued entry
    vecs.push_back(mk(1,1,'h11,   1,9,1,    9,0, 1,1,'h11,  1,1,1,0));
    vecs.push_back(mk(1,9,2,      0,0,0,    9,0, 1,9,2,     1,0,1,0));
    vecs.push_back(mk(0,0,0,      0,0,0,    9,0, 0,9,2,     1,0,0,0));
    vecs.push_back(mk(0,0,0,      0,0,0,    9,0, 0,9,2,     1,0,0,0));
    // youngest-wins against a same-cycle MDU transfer
    vecs.push_back(mk(1,4,'h40,   1,4,'h41, 4,0, 1,4,'h40,  1,0,1,0));
    vecs.push_back(mk(0,0,0,      0,0,0,    4,0, 0,4,'h40,  1,0,0,0));
    // backpressure: 6 pipe cycles, 5 MDU results, producer holds the 5th
    vecs.push_back(mk(1,1,'hA1,   1,20,'h200,24,20, 1,1,'hA1,  1,1,0,1));
    vecs.push_back(mk(1,2,'hA2,   1,21,'h201,24,20, 1,2,'hA2,  1,2,0,1));
    vecs.push_back(mk(1,3,'hA3,   1,22,'h202,24,20, 1,3,'hA3,  1,3,0,1));
    vecs.push_back(mk(1,4,'hA4,   1,23,'h203,24,20, 1,4,'hA4,  0,4,0,1));
    vecs.push_back(mk(1,5,'hA5,   1,24,'h204,24,20, 1,5,'hA5,  0,4,0,1));
    vecs.push_back(mk(1,6,'hA6,   1,24,'h204,24,20, 1,6,'hA6,  0,4,0,1));
    vecs.push_back(mk(0,0,0,      1,24,'h204,24,20, 1,20,'h200,1,3,0,1));
    vecs.push_back(mk(0,0,0,      1,24,'h204,24,20, 1,21,'h201,1,3,1,0));
    vecs.push_back(mk(0,0,0,      0,0,0,     24,20, 1,22,'h202,1,2,1,0));
    vecs.push_back(mk(0,0,0,      0,0,0,     24,20, 1,23,'h203,1,1,1,0));
    vecs.push_back(mk(0,0,0,      0,0,0,     24,20, 1,24,'h204,1,0,1,0));
    vecs.push_back(mk(0,0,0,      0,0,0,     24,20, 0,24,'h204,1,0,0,0));

    rst = 1'b1;
    idle();
    rs = 5'd0; rt = 5'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_reg_write",  0, 32'(reg_write),  32'd0);
    chk("rst_rd",         0, 32'(rd),         32'd0);
    chk("rst_write_data", 0, write_data,      32'd0);
    chk("rst_mdu_ready",  0, 32'(mdu_ready),  32'd1);
    chk("rst_pend_count", 0, 32'(pend_count), 32'd0);
    chk("rst_rs_pending", 0, 32'(rs_pending), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_vec(vecs[i], i);
    end

    // reset mid-drain: queue three MDU results behind pipe writes
    rs = 5'd12; rt = 5'd16;
    for (int k = 0; k < 3; k++) begin
      pipe_valid = 1'b1; pipe_rd = 5'(11 + 2*k); pipe_data = 32'h300 + k;
      mdu_valid  = 1'b1; mdu_rd  = 5'(12 + 2*k); mdu_data  = 32'h400 + k;
      @(negedge clk);
    end
    idle();
    chk("fill_pend_count", 100, 32'(pend_count), 32'd3);
    chk("fill_rs_pending", 100, 32'(rs_pending), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_reg_write",  101, 32'(reg_write),  32'd0);
    chk("arst_rd",         101, 32'(rd),         32'd0);
    chk("arst_write_data", 101, write_data,      32'd0);
    chk("arst_pend_count", 101, 32'(pend_count), 32'd0);
    chk("arst_mdu_ready",  101, 32'(mdu_ready),  32'd1);
    chk("arst_rs_pending", 101, 32'(rs_pending), 32'd0);
    chk("arst_rt_pending", 101, 32'(rt_pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_reg_write",  102 + k, 32'(reg_write),  32'd0);
      chk("post_rst_pend_count", 102 + k, 32'(pend_count), 32'd0);
      chk("post_rst_rs_pending", 102 + k, 32'(rs_pending), 32'd0);
    end

    // a fresh MDU result after release bypasses straight to the output
    mdu_valid = 1'b1; mdu_rd = 5'd17; mdu_data = 32'h500;
    @(negedge clk);
    idle();
    chk("post_rst_byp_rw",   110, 32'(reg_write), 32'd1);
    chk("post_rst_byp_rd",   110, 32'(rd),        32'd17);
    chk("post_rst_byp_data", 110, write_data,     32'h500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
